ccta_seq: RTL and testbench

Operand sequencer and result collector for the CCTA arithmetic block. It drives the CCTA input side (`A`, `B`, `C`, `ctrl`, DUT reset) and consumes its 5-bit `q` output. On `start` it runs a fixed campaign: a DUT-reset hold, then `BEATS` pseudo-random operand triples with `ctrl=0`, then `BEATS` triples with `ctrl=1`. Every returned `q` is folded into a running sum and a rotate-XOR signature, for on-chip self-test and board bring-up.

---
 rtl/ccta_seq.sv | 124 ++++++++++++
 tb/tb_ccta_seq.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ccta_seq.sv
// rtl/ccta_seq.sv - operand sequencer and result collector for the CCTA block
module ccta_seq #(
    parameter int          BEATS = 10,
    parameter int          HOLD  = 5,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [3:0]  A,
    output logic [3:0]  B,
    output logic [3:0]  C,
    output logic        ctrl,
    output logic        dut_rst,
    input  logic [4:0]  q,
    output logic        busy,
    output logic        done,
    output logic [15:0] sum,
    output logic [4:0]  sig
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HOLD  = 3'd1;
    localparam logic [2:0] S_RUN0  = 3'd2;
    localparam logic [2:0] S_RUN1  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [7:0]  HOLD_LAST  = 8'(HOLD - 1);
    localparam logic [7:0]  BEATS_LAST = 8'(BEATS - 1);
    // An all-zero Galois LFSR would lock up, so a zero seed is promoted to 1.
    localparam logic [15:0] SEED_EFF   = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;

    logic [2:0]  r_state;
    logic [7:0]  r_cnt;
    logic [15:0] r_lfsr;
    logic        r_vld;
    logic [15:0] r_sum;
    logic [4:0]  r_sig;

    logic        w_run;
    logic        w_start;
    logic [15:0] w_lfsr_nxt;

    assign w_run      = (r_state == S_RUN0) || (r_state == S_RUN1);
    assign w_start    = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_lfsr_nxt = (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0000);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_lfsr  <= SEED_EFF;
            r_vld   <= 1'b0;
            r_sum   <= 16'd0;
            r_sig   <= 5'd0;
        end else begin
            // q answers the beat presented on the previous cycle.
            r_vld <= w_run;
            if (w_run) begin
                r_lfsr <= w_lfsr_nxt;
            end
            if (r_vld) begin
                r_sum <= r_sum + {11'd0, q};
                r_sig <= {r_sig[3:0], r_sig[4]} ^ q;
            end

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start) begin
                        r_state <= S_HOLD;
                        r_cnt   <= 8'd0;
                        r_lfsr  <= SEED_EFF;
                        r_sum   <= 16'd0;
                        r_sig   <= 5'd0;
                    end
                end
                S_HOLD: begin
                    if (r_cnt == HOLD_LAST) begin
                        r_state <= S_RUN0;
                        r_cnt   <= 8'd0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_RUN0: begin
                    if (r_cnt == BEATS_LAST) begin
                        r_state <= S_RUN1;
                        r_cnt   <= 8'd0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_RUN1: begin
                    if (r_cnt == BEATS_LAST) begin
                        r_state <= S_DRAIN;
                        r_cnt   <= 8'd0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_DRAIN: begin
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 8'd0;
                end
            endcase
        end
    end

    assign A       = w_run ? r_lfsr[3:0]  : 4'd0;
    assign B       = w_run ? r_lfsr[7:4]  : 4'd0;
    assign C       = w_run ? r_lfsr[11:8] : 4'd0;
    assign ctrl    = (r_state == S_RUN1);
    assign dut_rst = (r_state == S_IDLE) || (r_state == S_HOLD);
    assign busy    = (r_state == S_HOLD) || w_run || (r_state == S_DRAIN);
    assign done    = (r_state == S_DONE);
    assign sum     = r_sum;
    assign sig     = r_sig;

endmodule

// File: tb/tb_ccta_seq.sv
// tb/tb_ccta_seq.sv - directed bench for ccta_seq with a registered adder standing in for CCTA
module tb_ccta_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance a: BEATS=2, HOLD=1, q from a registered A+B+C model
    logic        start_a;
    logic [3:0]  A_a, B_a, C_a;
    logic        ctrl_a, dut_rst_a, busy_a, done_a;
    logic [4:0]  q_a, sig_a;
    logic [15:0] sum_a;

    // Instance b: BEATS=1, HOLD=1, q driven directly
    logic        start_b;
    logic [3:0]  A_b, B_b, C_b;
    logic        ctrl_b, dut_rst_b, busy_b, done_b;
    logic [4:0]  q_b, sig_b;
    logic [15:0] sum_b;

    // Instance c: default parameters, q driven directly
    logic        start_c;
    logic [3:0]  A_c, B_c, C_c;
    logic        ctrl_c, dut_rst_c, busy_c, done_c;
    logic [4:0]  q_c, sig_c;
    logic [15:0] sum_c;

    ccta_seq #(.BEATS(2), .HOLD(1)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .A(A_a), .B(B_a), .C(C_a),
        .ctrl(ctrl_a), .dut_rst(dut_rst_a), .q(q_a), .busy(busy_a),
        .done(done_a), .sum(sum_a), .sig(sig_a)
    );

    ccta_seq #(.BEATS(1), .HOLD(1)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .A(A_b), .B(B_b), .C(C_b),
        .ctrl(ctrl_b), .dut_rst(dut_rst_b), .q(q_b), .busy(busy_b),
        .done(done_b), .sum(sum_b), .sig(sig_b)
    );

    ccta_seq u_c (
        .clk(clk), .rst(rst), .start(start_c), .A(A_c), .B(B_c), .C(C_c),
        .ctrl(ctrl_c), .dut_rst(dut_rst_c), .q(q_c), .busy(busy_c),
        .done(done_c), .sum(sum_c), .sig(sig_c)
    );

    always @(posedge clk) begin
        if (dut_rst_a) q_a <= 5'd0;
        else           q_a <= {1'b0, A_a} + {1'b0, B_a} + {1'b0, C_a};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full campaign on instance a: beats (1,E,C) (0,7,2) (8,3,1) (C,9,8) -> q 27,9,12,29
    task automatic run_seq_a(input string tag);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk({tag, " t1 busy"}, busy_a, 1);
        chk({tag, " t1 dut_rst"}, dut_rst_a, 1);
        chk({tag, " t1 A"}, A_a, 0);
        chk({tag, " t1 sum clr"}, sum_a, 0);
        chk({tag, " t1 sig clr"}, sig_a, 0);
        tick();
        chk({tag, " t2 ABC"}, {A_a, B_a, C_a}, 12'h1EC);
        chk({tag, " t2 ctrl"}, ctrl_a, 0);
        chk({tag, " t2 dut_rst"}, dut_rst_a, 0);
        tick();
        chk({tag, " t3 ABC"}, {A_a, B_a, C_a}, 12'h072);
        chk({tag, " t3 ctrl"}, ctrl_a, 0);
        tick();
        chk({tag, " t4 ABC"}, {A_a, B_a, C_a}, 12'h831);
        chk({tag, " t4 ctrl"}, ctrl_a, 1);
        tick();
        chk({tag, " t5 ABC"}, {A_a, B_a, C_a}, 12'hC98);
        chk({tag, " t5 ctrl"}, ctrl_a, 1);
        tick();
        chk({tag, " t6 drain busy/done/ctrl"}, {busy_a, done_a, ctrl_a}, 3'b100);
        chk({tag, " t6 ABC"}, {A_a, B_a, C_a}, 12'h000);
        tick();
        chk({tag, " t7 busy/done"}, {busy_a, done_a}, 2'b01);
        chk({tag, " t7 sum"}, sum_a, 77);
        chk({tag, " t7 sig"}, sig_a, 30);
        tick();
        chk({tag, " t8 hold sum"}, sum_a, 77);
        chk({tag, " t8 done level"}, done_a, 1);
    endtask

    int n_busy;
    int guard;

    initial begin
        rst = 1'b1;
        start_a = 1'b1; start_b = 1'b1; start_c = 1'b1;
        q_b = 5'd1; q_c = 5'd31;

        // reset with start asserted
        tick();
        tick();
        chk("rst ABC", {A_a, B_a, C_a}, 12'h000);
        chk("rst ctrl", ctrl_a, 0);
        chk("rst dut_rst", dut_rst_a, 1);
        chk("rst busy", busy_a, 0);
        chk("rst done", done_a, 0);
        chk("rst sum", sum_a, 0);
        chk("rst sig", sig_a, 0);
        chk("rst c busy/dut_rst", {busy_c, dut_rst_c}, 2'b01);
        rst = 1'b0;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        tick();
        chk("idle stays", {busy_a, done_a, dut_rst_a}, 3'b001);

        run_seq_a("seq1");

        // start during RUN0 is ignored, rst during RUN1 aborts
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick();
        chk("abort t2 ABC", {A_a, B_a, C_a}, 12'h1EC);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("ign t3 ABC", {A_a, B_a, C_a}, 12'h072);
        chk("ign t3 ctrl", ctrl_a, 0);
        tick();
        chk("ign t4 ctrl", ctrl_a, 1);
        chk("ign t4 ABC", {A_a, B_a, C_a}, 12'h831);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort busy/done/dut_rst", {busy_a, done_a, dut_rst_a}, 3'b001);
        chk("abort sum", sum_a, 0);
        chk("abort sig", sig_a, 0);
        chk("abort ABC", {A_a, B_a, C_a}, 12'h000);

        run_seq_a("after abort");
        run_seq_a("from done");

        // BEATS=1 HOLD=1, q tied to 1
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        tick(); tick(); tick();
        chk("b t4 busy/done", {busy_b, done_b}, 2'b10);
        tick();
        chk("b t5 busy/done", {busy_b, done_b}, 2'b01);
        chk("b sum q1", sum_b, 2);
        chk("b sig q1", sig_b, 3);
        q_b = 5'd0;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        chk("b restart clr", {sum_b, 3'b000, sig_b}, 24'h0);
        tick(); tick(); tick(); tick();
        chk("b done q0", done_b, 1);
        chk("b sum q0", sum_b, 0);
        chk("b sig q0", sig_b, 0);

        // default parameters, q tied to 31
        start_c = 1'b1;
        tick();
        start_c = 1'b0;
        n_busy = 0;
        guard = 0;
        while (!done_c && guard < 100) begin
            if (busy_c) n_busy++;
            tick();
            guard++;
        end
        chk("c done reached", done_c, 1);
        chk("c busy cycles", n_busy, 26);
        chk("c sum", sum_c, 620);
        chk("c sig", sig_c, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
